vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator with built-in test-pattern source. It drives the monitor connector (hs, vs, 3-bit RGB) directly and exports pixel coordinates, data-enable and a pixel strobe for a future frame-buffer reader. Timing, sync polarity and the pixel-clock divide ratio are parameters, so one block serves 640x400 and 640x480 modes.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 400, visible lines
- V_FRONT, 12, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 35, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active low)
- V_SYNC_POL, 1, vsync active level
- CLK_DIV, 2, system clocks per pixel, >= 1
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels
- clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- mode  in  2  pattern: 0 black, 1 white, 2 colour bars, 3 checkerboard
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- r, g, b  out  1 each  pixel colour, 0 outside visible area
- de  out  1  visible-area data enable
- x  out  H_W  visible column, 0 when de = 0 (H_W = $clog2(H_TOTAL))
- y  out  V_W  visible row, 0 when de = 0 (V_W = $clog2(V_TOTAL))
- pix_stb  out  1  one-clock pulse each time outputs update
- frame_start  out  1  high for the pixel period of pixel (0,0)

## Operation
- H_TOTAL = sum of H_* lengths (default 800); V_TOTAL likewise (default 449).
- Line layout: visible [0, H_VISIBLE), front porch, sync, back porch. hsync active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) = [656, 752) by default. Vertical is identical per line: vsync active for v in [412, 414).
- Divider div counts 0..CLK_DIV-1 and wraps; pix_en = (div == CLK_DIV-1). With CLK_DIV = 1, pix_en is constant 1.
- On pix_en: h increments, wrapping H_TOTAL-1 -> 0; on h wrap v increments, wrapping V_TOTAL-1 -> 0.
- Active region: h < H_VISIBLE and v < V_VISIBLE.
- Pattern (active region only):
  - mode 2: eight equal bars, BAR_W = H_VISIBLE/8; bar index k = 0..7 from the left; {r,g,b} = 7-k, so white first, black last. Bar index comes from a bar counter, not a divider.
  - mode 3: {r,g,b} = {3{h[CHK_LOG2] ^ v[CHK_LOG2]}}.
- mode is sampled into mode_q only when pix_en and (h,v) = (0,0). A change takes effect on the next frame and never splits a frame.

## Timing
- Outputs are registered and load only on pix_en clocks, from the pre-increment (h,v). They hold for CLK_DIV clocks.
- Latency: counter value to pins is 1 clock. pix_stb is the registered pix_en, coincident with the output change.
- Reset (rst_n = 0 at an edge) sets:
  - div, h, v, mode_q = 0
  - hs = ~H_SYNC_POL, vs = ~V_SYNC_POL
  - de, r, g, b, x, y, pix_stb, frame_start = 0
- After release, the first pix_en occurs on clock CLK_DIV-1. The first output pixel is (0,0) with frame_start = 1.
- Reset mid-line or mid-frame aborts immediately. There is no partial-line completion; the raster restarts at (0,0).
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1) returns to (0,0) in one pix_en.

## Structure
- Package vga_pkg holds:
  - mode encodings (MODE_BLACK, MODE_WHITE, MODE_BARS, MODE_CHECK)
  - localparam timing sets for 640x400@70 and 640x480@60
  - a function returning the total from visible/front/sync/back
- Sub-module vga_axis_counter, instantiated twice (h, v):
  - ports: clock, rst_n, en, count, wrap
  - parameters: VISIBLE, FRONT, SYNC, BACK, POL
  - outputs: active, sync (polarity applied), wrap
- Top-level vga_timing_gen holds the divider, bar counter, mode_q, pattern mux and output registers.

## Test plan
- Reset: hold rst_n low 5 clocks with mode = 2 -> hs = 1, vs = 0, rgb = 000, de = 0. First pix_stb arrives 2 clocks after release (CLK_DIV = 2), with frame_start = 1.
- Line and frame timing, defaults:
  - hs period is 1600 clocks; hs is low for 192 clocks starting at pixel 656.
  - vs is high for exactly lines 412-413; frame period is 718400 clocks.
- Data enable: over one frame, count de-high pix_stb = 256000. Max x = 639, max y = 399; x = y = 0 whenever de = 0.
- Colour bars (mode 2):
  - x = 0 -> 111; x = 80 -> 110; x = 639 -> 000.
  - rgb = 000 at h = 640..799.
- Checkerboard (mode 3): (x=0,y=0) -> 000; (32,0) -> 111; (32,32) -> 000. Switching to mode 1 at line 200 leaves mode 3 in force until the next frame_start, then white.
- Mid-frame reset at (h=300, v=250), plus a CLK_DIV = 1 / 640x480 run:
  - the reset restarts at (0,0) with a frame_start pulse;
  - the 640x480 run gives line period 800 clocks, frame 525 lines, hs and vs both active low.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared mode encodings, standard 640-wide timing sets and the line/frame
// total helper used by the VGA raster generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_WHITE = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // 640x400 @ 70 Hz
    localparam int VGA400_H_VISIBLE = 640;
    localparam int VGA400_H_FRONT   = 16;
    localparam int VGA400_H_SYNC    = 96;
    localparam int VGA400_H_BACK    = 48;
    localparam int VGA400_V_VISIBLE = 400;
    localparam int VGA400_V_FRONT   = 12;
    localparam int VGA400_V_SYNC    = 2;
    localparam int VGA400_V_BACK    = 35;
    localparam bit VGA400_H_POL     = 1'b0;
    localparam bit VGA400_V_POL     = 1'b1;

    // 640x480 @ 60 Hz
    localparam int VGA480_H_VISIBLE = 640;
    localparam int VGA480_H_FRONT   = 16;
    localparam int VGA480_H_SYNC    = 96;
    localparam int VGA480_H_BACK    = 48;
    localparam int VGA480_V_VISIBLE = 480;
    localparam int VGA480_V_FRONT   = 10;
    localparam int VGA480_V_SYNC    = 2;
    localparam int VGA480_V_BACK    = 33;
    localparam bit VGA480_H_POL     = 1'b0;
    localparam bit VGA480_V_POL     = 1'b0;

    function automatic int vga_total(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Monitor-side and frame-buffer-side outputs of the raster generator.
interface vga_timing_gen_if #(
    parameter int H_W = 10,
    parameter int V_W = 9
);
    logic           hs;
    logic           vs;
    logic           r;
    logic           g;
    logic           b;
    logic           de;
    logic [H_W-1:0] x;
    logic [V_W-1:0] y;
    logic           pix_stb;
    logic           frame_start;

    modport master (output hs, vs, r, g, b, de, x, y, pix_stb, frame_start);
    modport slave  (input  hs, vs, r, g, b, de, x, y, pix_stb, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag, visible-region flag and
// sync output with polarity applied.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0,
    parameter int W       = $clog2(vga_total(VISIBLE, FRONT, SYNC, BACK))
) (
    input  logic         i_clock,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_active,
    output logic         o_sync
);
    localparam int TOTAL      = vga_total(VISIBLE, FRONT, SYNC, BACK);
    localparam int SYNC_START = VISIBLE + FRONT;
    localparam int SYNC_END   = SYNC_START + SYNC;

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_en)
            r_count <= o_wrap ? '0 : r_count + W'(1);
    end

    assign o_count  = r_count;
    assign o_wrap   = (r_count == W'(TOTAL - 1));
    assign o_active = (r_count < W'(VISIBLE));
    assign o_sync   = ((r_count >= W'(SYNC_START)) && (r_count < W'(SYNC_END))) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel-clock divider, test-pattern source
// and registered monitor / frame-buffer outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 400,
    parameter int V_FRONT    = 12,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 35,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int CLK_DIV    = 2,
    parameter int CHK_LOG2   = 5
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic           w_pix_en;
    logic [H_W-1:0] w_h;
    logic [V_W-1:0] w_v;
    logic           w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_hs, w_vs;
    logic           w_active;
    mode_e          w_mode;
    logic [2:0]     w_rgb;

    logic            r_origin;
    mode_e           r_mode_q;
    logic [BP_W-1:0] r_bar_px;
    logic [2:0]      r_bar_idx;
    logic            r_hs, r_vs, r_de, r_pix_stb, r_fs;
    logic [2:0]      r_rgb;
    logic [H_W-1:0]  r_x;
    logic [V_W-1:0]  r_y;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign w_pix_en = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            logic [DIV_W-1:0] r_div;
            always_ff @(posedge i_clock) begin
                if (!i_rst_n)
                    r_div <= '0;
                else if (w_pix_en)
                    r_div <= '0;
                else
                    r_div <= r_div + DIV_W'(1);
            end
            assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));
        end
    endgenerate

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(H_SYNC_POL), .W(H_W)
    ) u_h (
        .i_clock(i_clock), .i_rst_n(i_rst_n), .i_en(w_pix_en),
        .o_count(w_h), .o_wrap(w_h_wrap), .o_active(w_h_act), .o_sync(w_hs)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(V_SYNC_POL), .W(V_W)
    ) u_v (
        .i_clock(i_clock), .i_rst_n(i_rst_n), .i_en(w_pix_en & w_h_wrap),
        .o_count(w_v), .o_wrap(w_v_wrap), .o_active(w_v_act), .o_sync(w_vs)
    );

    assign w_active = w_h_act & w_v_act;
    // Pixel (0,0) takes the live mode so the whole frame uses the value latched there.
    assign w_mode   = r_origin ? mode_e'(i_mode) : r_mode_q;

    always_comb begin
        w_rgb = 3'b000;
        case (w_mode)
            MODE_WHITE: w_rgb = 3'b111;
            MODE_BARS:  w_rgb = 3'd7 - r_bar_idx;
            MODE_CHECK: w_rgb = {3{w_h[CHK_LOG2] ^ w_v[CHK_LOG2]}};
            default:    w_rgb = 3'b000;
        endcase
    end

    // Bar counter tracks the current h: pixel-within-bar and bar index.
    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (w_pix_en && w_h_wrap) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (w_pix_en && w_h_act) begin
            if (r_bar_px == BP_W'(BAR_W - 1)) begin
                r_bar_px  <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= r_bar_px + BP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_origin  <= 1'b1;
            r_mode_q  <= MODE_BLACK;
            r_hs      <= ~H_SYNC_POL;
            r_vs      <= ~V_SYNC_POL;
            r_de      <= 1'b0;
            r_rgb     <= 3'b000;
            r_x       <= '0;
            r_y       <= '0;
            r_pix_stb <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_pix_stb <= w_pix_en;
            if (w_pix_en) begin
                r_origin <= w_h_wrap & w_v_wrap;
                if (r_origin)
                    r_mode_q <= mode_e'(i_mode);
                r_hs  <= w_hs;
                r_vs  <= w_vs;
                r_de  <= w_active;
                r_rgb <= w_active ? w_rgb : 3'b000;
                r_x   <= w_active ? w_h : '0;
                r_y   <= w_active ? w_v : '0;
                r_fs  <= r_origin;
            end
        end
    end

    assign vif.hs          = r_hs;
    assign vif.vs          = r_vs;
    assign vif.r           = r_rgb[2];
    assign vif.g           = r_rgb[1];
    assign vif.b           = r_rgb[0];
    assign vif.de          = r_de;
    assign vif.x           = r_x;
    assign vif.y           = r_y;
    assign vif.pix_stb     = r_pix_stb;
    assign vif.frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two scaled-down instances (CLK_DIV=2 and CLK_DIV=1)
// checked against a pixel-index reference model plus targeted timing probes.
module tb_vga_timing_gen;

    localparam int A_HV = 64, A_HF = 4, A_HS = 8, A_HB = 4;
    localparam int A_VV = 24, A_VF = 2, A_VS = 2, A_VB = 4;
    localparam int A_DIV = 2, A_CHK = 3;
    localparam bit A_HP = 1'b0, A_VP = 1'b1;
    localparam int A_HT = 80, A_VT = 32, A_HW = 7, A_VW = 5;

    localparam int B_HV = 48, B_HF = 2, B_HS = 6, B_HB = 8;
    localparam int B_VV = 20, B_VF = 1, B_VS = 3, B_VB = 6;
    localparam int B_DIV = 1, B_CHK = 2;
    localparam bit B_HP = 1'b0, B_VP = 1'b0;
    localparam int B_HT = 64, B_VT = 30, B_HW = 6, B_VW = 5;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [2:0]  rgb;
        logic        fs;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
    int         checks = 0, fails = 0;

    vga_timing_gen_if #(.H_W(A_HW), .V_W(A_VW)) ifa ();
    vga_timing_gen_if #(.H_W(B_HW), .V_W(B_VW)) ifb ();

    vga_timing_gen #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .H_SYNC_POL(A_HP), .V_SYNC_POL(A_VP), .CLK_DIV(A_DIV), .CHK_LOG2(A_CHK)
    ) dut_a (.i_clock(clk), .i_rst_n(rst_a), .i_mode(mode_a), .vif(ifa));

    vga_timing_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .H_SYNC_POL(B_HP), .V_SYNC_POL(B_VP), .CLK_DIV(B_DIV), .CHK_LOG2(B_CHK)
    ) dut_b (.i_clock(clk), .i_rst_n(rst_b), .i_mode(mode_b), .vif(ifb));

    // Expected pins for the p-th pixel since reset (p < 0: nothing shown yet).
    function automatic exp_t ref_out(int p, int m, int hv, int hf, int hsw, int hb,
                                     int vv, int vf, int vsw, int vb, bit hp, bit vp, int chk);
        exp_t e;
        int ht, vt, h, v;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        if (p < 0) return e;
        h = p % ht;
        v = (p / ht) % vt;
        e.hs = (h >= hv + hf && h < hv + hf + hsw) ? hp : ~hp;
        e.vs = (v >= vv + vf && v < vv + vf + vsw) ? vp : ~vp;
        e.fs = (h == 0 && v == 0);
        e.de = (h < hv && v < vv);
        if (e.de) begin
            e.x = h;
            e.y = v;
            case (m)
                1: e.rgb = 3'd7;
                2: e.rgb = 3'(7 - h / (hv / 8));
                3: e.rgb = ((((h >> chk) ^ (v >> chk)) & 1) != 0) ? 3'd7 : 3'd0;
                default: e.rgb = 3'd0;
            endcase
        end
        return e;
    endfunction

    // Model state: clocks since release, pixels emitted, mode latched at frame start.
    int ma_cyc = 0, ma_pix = -1, ma_fm = 0;
    int mb_cyc = 0, mb_pix = -1, mb_fm = 0;

    always @(posedge clk) begin
        if (!rst_a) begin
            ma_cyc <= 0;
            ma_pix <= -1;
        end else begin
            ma_cyc <= ma_cyc + 1;
            if ((ma_cyc + 1) % A_DIV == 0) begin
                ma_pix <= ma_pix + 1;
                if ((ma_pix + 1) % (A_HT * A_VT) == 0) ma_fm <= int'(mode_a);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_b) begin
            mb_cyc <= 0;
            mb_pix <= -1;
        end else begin
            mb_cyc <= mb_cyc + 1;
            if ((mb_cyc + 1) % B_DIV == 0) begin
                mb_pix <= mb_pix + 1;
                if ((mb_pix + 1) % (B_HT * B_VT) == 0) mb_fm <= int'(mode_b);
            end
        end
    end

    task automatic wait_frame_a(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = (ifa.pix_stb === 1'b1 && ifa.frame_start === 1'b1);
        end
    endtask

    task automatic test_reset();
        mode_a = 2'd2;
        rst_a  = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({ifa.hs, ifa.vs} !== 2'b10) begin
            fails++; $display("FAIL reset_sync: got hs,vs=%b want 10", {ifa.hs, ifa.vs});
        end
        checks++;
        if ({ifa.r, ifa.g, ifa.b, ifa.de, ifa.pix_stb, ifa.frame_start} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got rgb,de,stb,fs=%b want 000000",
                              {ifa.r, ifa.g, ifa.b, ifa.de, ifa.pix_stb, ifa.frame_start});
        end
        checks++;
        if (ifa.x !== '0 || ifa.y !== '0) begin
            fails++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", ifa.x, ifa.y);
        end
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (ifa.pix_stb !== 1'b0) begin
            fails++; $display("FAIL first_stb_early: got pix_stb=%b want 0 one clock after release", ifa.pix_stb);
        end
        @(negedge clk);
        checks++;
        if ({ifa.pix_stb, ifa.frame_start, ifa.de, ifa.r, ifa.g, ifa.b} !== 6'b111111) begin
            fails++; $display("FAIL first_pixel: got stb,fs,de,rgb=%b want 111111",
                              {ifa.pix_stb, ifa.frame_start, ifa.de, ifa.r, ifa.g, ifa.b});
        end
    endtask

    task automatic test_line_timing();
        bit prev, found;
        int n, c_fp, c_low, c_high, v_high, v_low, hs_falls;
        prev = ifa.de; found = 1'b0; n = 0;
        while (!found && n < 3000) begin
            @(negedge clk); n++;
            found = prev && !ifa.de;
            prev  = ifa.de;
        end
        c_fp = 0;
        while (ifa.hs !== 1'b0 && c_fp < 1000) begin @(negedge clk); c_fp++; end
        c_low = 0;
        while (ifa.hs === 1'b0 && c_low < 1000) begin @(negedge clk); c_low++; end
        c_high = 0;
        while (ifa.hs === 1'b1 && c_high < 1000) begin @(negedge clk); c_high++; end
        checks++;
        if (!found || c_fp != A_HF * A_DIV) begin
            fails++; $display("FAIL hs_start: got %0d clocks de-fall to hs-fall want %0d", c_fp, A_HF * A_DIV);
        end
        checks++;
        if (c_low != A_HS * A_DIV) begin
            fails++; $display("FAIL hs_width: got %0d want %0d", c_low, A_HS * A_DIV);
        end
        checks++;
        if (c_low + c_high != A_HT * A_DIV) begin
            fails++; $display("FAIL hs_period: got %0d want %0d", c_low + c_high, A_HT * A_DIV);
        end
        n = 0;
        while (ifa.vs !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        v_high = 0; hs_falls = 0; prev = ifa.hs;
        while (ifa.vs === 1'b1 && v_high < 1000) begin
            @(negedge clk); v_high++;
            if (prev && !ifa.hs && ifa.vs) hs_falls++;
            prev = ifa.hs;
        end
        v_low = 0;
        while (ifa.vs === 1'b0 && v_low < 6000) begin @(negedge clk); v_low++; end
        checks++;
        if (v_high != A_VS * A_HT * A_DIV || hs_falls != A_VS) begin
            fails++; $display("FAIL vs_width: got %0d clocks, %0d lines want %0d clocks, %0d lines",
                              v_high, hs_falls, A_VS * A_HT * A_DIV, A_VS);
        end
        checks++;
        if (v_high + v_low != A_HT * A_VT * A_DIV) begin
            fails++; $display("FAIL frame_period: got %0d want %0d", v_high + v_low, A_HT * A_VT * A_DIV);
        end
    endtask

    task automatic test_frame();
        bit ok;
        int de_cnt, max_x, max_y, bad, fs_cnt;
        de_cnt = 0; max_x = 0; max_y = 0; bad = 0; fs_cnt = 0;
        wait_frame_a(6000, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL frame_wait: got timeout want frame_start"); end
        for (int i = 0; i < A_HT * A_VT * A_DIV; i++) begin
            if (i > 0) @(negedge clk);
            if (ifa.pix_stb === 1'b1) begin
                if (ifa.frame_start === 1'b1) fs_cnt++;
                if (ifa.de === 1'b1) begin
                    de_cnt++;
                    if (int'(ifa.x) > max_x) max_x = int'(ifa.x);
                    if (int'(ifa.y) > max_y) max_y = int'(ifa.y);
                end else if (ifa.x !== '0 || ifa.y !== '0) bad++;
            end
        end
        checks++;
        if (de_cnt != A_HV * A_VV) begin
            fails++; $display("FAIL de_count: got %0d want %0d", de_cnt, A_HV * A_VV);
        end
        checks++;
        if (max_x != A_HV - 1 || max_y != A_VV - 1) begin
            fails++; $display("FAIL max_xy: got %0d,%0d want %0d,%0d", max_x, max_y, A_HV - 1, A_VV - 1);
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL xy_blank: got %0d nonzero x/y with de=0 want 0", bad); end
        checks++;
        if (fs_cnt != 1) begin fails++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
    endtask

    task automatic test_bars();
        bit ok;
        logic [2:0] c0, c8, c63, rgb;
        int blank_bad, bar_bad;
        c0 = 'x; c8 = 'x; c63 = 'x; blank_bad = 0; bar_bad = 0;
        mode_a = 2'd2;
        wait_frame_a(6000, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL bars_wait: got timeout want frame_start"); end
        for (int i = 0; i < A_HT * A_VT * A_DIV; i++) begin
            if (i > 0) @(negedge clk);
            rgb = {ifa.r, ifa.g, ifa.b};
            if (ifa.pix_stb === 1'b1) begin
                if (ifa.de !== 1'b1) begin
                    if (rgb !== 3'b000) blank_bad++;
                end else begin
                    if (ifa.y == 5 && ifa.x == 0)  c0 = rgb;
                    if (ifa.y == 5 && ifa.x == 8)  c8 = rgb;
                    if (ifa.y == 5 && ifa.x == 63) c63 = rgb;
                    if (int'(rgb) != 7 - int'(ifa.x) / (A_HV / 8)) bar_bad++;
                end
            end
        end
        checks++;
        if (c0 !== 3'b111) begin fails++; $display("FAIL bar_x0: got %b want 111", c0); end
        checks++;
        if (c8 !== 3'b110) begin fails++; $display("FAIL bar_x8: got %b want 110", c8); end
        checks++;
        if (c63 !== 3'b000) begin fails++; $display("FAIL bar_x63: got %b want 000", c63); end
        checks++;
        if (blank_bad != 0) begin fails++; $display("FAIL bar_blank: got %0d lit blank pixels want 0", blank_bad); end
        checks++;
        if (bar_bad != 0) begin fails++; $display("FAIL bar_index: got %0d wrong bar pixels want 0", bar_bad); end
    endtask

    task automatic test_checker();
        bit ok, switched;
        logic [2:0] c00, c80, c88, c016, c816, cnext, rgb;
        c00 = 'x; c80 = 'x; c88 = 'x; c016 = 'x; c816 = 'x; cnext = 'x; switched = 1'b0;
        mode_a = 2'd3;
        wait_frame_a(6000, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL chk_wait: got timeout want frame_start"); end
        for (int i = 0; i < A_HT * A_VT * A_DIV + 4; i++) begin
            if (i > 0) @(negedge clk);
            rgb = {ifa.r, ifa.g, ifa.b};
            if (ifa.pix_stb === 1'b1) begin
                if (i > 0 && ifa.frame_start === 1'b1) cnext = rgb;
                else if (ifa.de === 1'b1) begin
                    if (ifa.x == 0 && ifa.y == 0)  c00 = rgb;
                    if (ifa.x == 8 && ifa.y == 0)  c80 = rgb;
                    if (ifa.x == 8 && ifa.y == 8)  c88 = rgb;
                    if (ifa.x == 0 && ifa.y == 16) c016 = rgb;
                    if (ifa.x == 8 && ifa.y == 16) c816 = rgb;
                    if (ifa.y == 12 && !switched) begin mode_a = 2'd1; switched = 1'b1; end
                end
            end
        end
        checks++;
        if (c00 !== 3'b000) begin fails++; $display("FAIL chk_0_0: got %b want 000", c00); end
        checks++;
        if (c80 !== 3'b111) begin fails++; $display("FAIL chk_8_0: got %b want 111", c80); end
        checks++;
        if (c88 !== 3'b000) begin fails++; $display("FAIL chk_8_8: got %b want 000", c88); end
        checks++;
        if (c016 !== 3'b000 || c816 !== 3'b111) begin
            fails++; $display("FAIL chk_after_switch: got %b,%b want 000,111", c016, c816);
        end
        checks++;
        if (cnext !== 3'b111) begin fails++; $display("FAIL white_next_frame: got %b want 111", cnext); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            ok = (ifa.pix_stb === 1'b1 && ifa.de === 1'b1 && ifa.x == 30 && ifa.y == 15);
        end
        checks++;
        if (!ok) begin fails++; $display("FAIL midrst_wait: got timeout want pixel (30,15)"); end
        rst_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.de, ifa.pix_stb, ifa.hs, ifa.vs} !== 4'b0010 || ifa.x !== '0) begin
            fails++; $display("FAIL midrst_state: got de,stb,hs,vs=%b x=%0d want 0010 x=0",
                              {ifa.de, ifa.pix_stb, ifa.hs, ifa.vs}, ifa.x);
        end
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ifa.pix_stb, ifa.frame_start} !== 2'b11 || ifa.x !== '0 || ifa.y !== '0) begin
            fails++; $display("FAIL midrst_restart: got stb,fs=%b x=%0d y=%0d want 11 0 0",
                              {ifa.pix_stb, ifa.frame_start}, ifa.x, ifa.y);
        end
    endtask

    task automatic test_random_a();
        exp_t e;
        logic exp_stb;
        for (int i = 0; i < 2 * A_HT * A_VT * A_DIV; i++) begin
            @(negedge clk);
            e = ref_out(ma_pix, ma_fm, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_HP, A_VP, A_CHK);
            exp_stb = (ma_cyc > 0 && ma_cyc % A_DIV == 0);
            checks++;
            if ({ifa.hs, ifa.vs, ifa.de, ifa.r, ifa.g, ifa.b, ifa.frame_start, ifa.pix_stb, ifa.x, ifa.y} !==
                {e.hs, e.vs, e.de, e.rgb, e.fs, exp_stb, A_HW'(e.x), A_VW'(e.y)}) begin
                fails++;
                $display("FAIL rand_a pix %0d: got hs%b vs%b de%b rgb%b fs%b stb%b x%0d y%0d want hs%b vs%b de%b rgb%b fs%b stb%b x%0d y%0d",
                         ma_pix, ifa.hs, ifa.vs, ifa.de, {ifa.r, ifa.g, ifa.b}, ifa.frame_start, ifa.pix_stb,
                         ifa.x, ifa.y, e.hs, e.vs, e.de, e.rgb, e.fs, exp_stb, e.x, e.y);
            end
            if (i % 97 == 0) mode_a = 2'($urandom_range(0, 3));
            if (!rst_a) rst_a = 1'b1;
            else if ($urandom_range(0, 1999) == 0) rst_a = 1'b0;
        end
        rst_a = 1'b1;
    endtask

    task automatic test_div1();
        exp_t e;
        bit   prev_hs, prev_vs;
        int   hs_fall, hs_per, hs_low, vs_fall, vs_per, vs_low;
        hs_fall = -1; hs_per = 0; hs_low = 0; vs_fall = -1; vs_per = 0; vs_low = 0;
        mode_b = 2'd3;
        @(negedge clk);
        rst_b = 1'b1;
        prev_hs = ifb.hs; prev_vs = ifb.vs;
        for (int i = 0; i < 2 * B_HT * B_VT + B_HT; i++) begin
            @(negedge clk);
            e = ref_out(mb_pix, mb_fm, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_HP, B_VP, B_CHK);
            checks++;
            if ({ifb.hs, ifb.vs, ifb.de, ifb.r, ifb.g, ifb.b, ifb.frame_start, ifb.pix_stb, ifb.x, ifb.y} !==
                {e.hs, e.vs, e.de, e.rgb, e.fs, 1'b1, B_HW'(e.x), B_VW'(e.y)}) begin
                fails++;
                $display("FAIL div1 pix %0d: got hs%b vs%b de%b rgb%b fs%b stb%b x%0d y%0d want hs%b vs%b de%b rgb%b fs%b stb1 x%0d y%0d",
                         mb_pix, ifb.hs, ifb.vs, ifb.de, {ifb.r, ifb.g, ifb.b}, ifb.frame_start, ifb.pix_stb,
                         ifb.x, ifb.y, e.hs, e.vs, e.de, e.rgb, e.fs, e.x, e.y);
            end
            if (prev_hs && !ifb.hs) begin if (hs_fall >= 0) hs_per = i - hs_fall; hs_fall = i; end
            if (!prev_hs && ifb.hs && hs_fall >= 0) hs_low = i - hs_fall;
            if (prev_vs && !ifb.vs) begin if (vs_fall >= 0) vs_per = i - vs_fall; vs_fall = i; end
            if (!prev_vs && ifb.vs && vs_fall >= 0) vs_low = i - vs_fall;
            prev_hs = ifb.hs; prev_vs = ifb.vs;
            if (i % 211 == 0) mode_b = 2'($urandom_range(0, 3));
        end
        checks++;
        if (hs_per != B_HT || hs_low != B_HS) begin
            fails++; $display("FAIL div1_hs: got period %0d low %0d want %0d %0d", hs_per, hs_low, B_HT, B_HS);
        end
        checks++;
        if (vs_per != B_HT * B_VT || vs_low != B_VS * B_HT) begin
            fails++; $display("FAIL div1_vs: got period %0d low %0d want %0d %0d",
                              vs_per, vs_low, B_HT * B_VT, B_VS * B_HT);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_bars();
        test_checker();
        test_mid_reset();
        test_random_a();
        test_div1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
